// File: rtl/tow_referee.sv
// Tug-of-war round/match referee: countdown, play, rope marker, round winner and match score.
// Optional feature: define TOW_FALSE_START_EN to punish pushes made during the countdown.
module tow_referee #(
    parameter int LEDS      = 9,
    parameter int COUNT_CYC = 25_000_000,
    parameter int MATCH     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            pl,
    input  logic            pr,
    output logic [LEDS-1:0] pos,
    output logic [1:0]      state,
    output logic            go,
    output logic            win_l,
    output logic            win_r,
    output logic [3:0]      score_l,
    output logic [3:0]      score_r,
    output logic            match_over
);

    localparam int              CW      = $clog2(COUNT_CYC + 1);
    localparam logic [CW-1:0]   RELOAD  = CW'(COUNT_CYC - 1);
    localparam logic [LEDS-1:0] CENTRE  = LEDS'(1) << (LEDS / 2);
    localparam logic [LEDS-1:0] GOAL_L  = LEDS'(1) << (LEDS - 1);
    localparam logic [LEDS-1:0] GOAL_R  = LEDS'(1);
    localparam logic [3:0]      MATCH_W = 4'(MATCH);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_PLAY, S_WIN} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [LEDS-1:0] r_pos;
    logic            r_go;
    logic            r_win_l;
    logic            r_win_r;
    logic [3:0]      r_score_l;
    logic [3:0]      r_score_r;
    logic            r_match;

    logic            w_push_l;
    logic            w_push_r;
    logic [LEDS-1:0] w_pos_l;
    logic [LEDS-1:0] w_pos_r;
    logic [3:0]      w_sl_inc;
    logic [3:0]      w_sr_inc;

    // Simultaneous pushes cancel, so only a lone push counts as a move.
    assign w_push_l = pl & ~pr;
    assign w_push_r = pr & ~pl;
    assign w_pos_l  = r_pos << 1;
    assign w_pos_r  = r_pos >> 1;
    assign w_sl_inc = r_score_l + 4'd1;
    assign w_sr_inc = r_score_r + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pos     <= CENTRE;
            r_go      <= 1'b0;
            r_win_l   <= 1'b0;
            r_win_r   <= 1'b0;
            r_score_l <= '0;
            r_score_r <= '0;
            r_match   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_COUNT;
                        r_cnt   <= RELOAD;
                    end
                end
                S_COUNT: begin
`ifdef TOW_FALSE_START_EN
                    // A push before the go signal hands the round to the opponent.
                    if (w_push_l) begin
                        r_state   <= S_WIN;
                        r_pos     <= GOAL_R;
                        r_win_r   <= 1'b1;
                        r_score_r <= w_sr_inc;
                        r_match   <= (w_sr_inc == MATCH_W);
                    end else if (w_push_r) begin
                        r_state   <= S_WIN;
                        r_pos     <= GOAL_L;
                        r_win_l   <= 1'b1;
                        r_score_l <= w_sl_inc;
                        r_match   <= (w_sl_inc == MATCH_W);
                    end else if (pl && pr) begin
                        r_cnt <= RELOAD;
                    end else
`endif
                    if (r_cnt == '0) begin
                        r_state <= S_PLAY;
                        r_go    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_PLAY: begin
                    if (w_push_l) begin
                        r_pos <= w_pos_l;
                        if (w_pos_l[LEDS-1]) begin
                            r_state   <= S_WIN;
                            r_go      <= 1'b0;
                            r_win_l   <= 1'b1;
                            r_score_l <= w_sl_inc;
                            r_match   <= (w_sl_inc == MATCH_W);
                        end
                    end else if (w_push_r) begin
                        r_pos <= w_pos_r;
                        if (w_pos_r[0]) begin
                            r_state   <= S_WIN;
                            r_go      <= 1'b0;
                            r_win_r   <= 1'b1;
                            r_score_r <= w_sr_inc;
                            r_match   <= (w_sr_inc == MATCH_W);
                        end
                    end
                end
                S_WIN: begin
                    if (start) begin
                        r_state <= S_COUNT;
                        r_cnt   <= RELOAD;
                        r_pos   <= CENTRE;
                        r_win_l <= 1'b0;
                        r_win_r <= 1'b0;
                        // A finished match starts the next one from zero.
                        if (r_match) begin
                            r_score_l <= '0;
                            r_score_r <= '0;
                            r_match   <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pos        = r_pos;
    assign state      = r_state;
    assign go         = r_go;
    assign win_l      = r_win_l;
    assign win_r      = r_win_r;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign match_over = r_match;

endmodule

// File: tb/tb_tow_referee.sv
// Self-checking bench for tow_referee (LEDS=5, COUNT_CYC=4, MATCH=2) using a queue-based scoreboard.
// Expectations follow TOW_FALSE_START_EN when the bench is compiled with that macro.
module tb_tow_referee;

    logic       clk = 1'b0;
    logic       rst, start, pl, pr;
    logic [4:0] pos;
    logic [1:0] state;
    logic       go, win_l, win_r, match_over;
    logic [3:0] score_l, score_r;

    typedef struct packed {
        logic [4:0] pos;
        logic [1:0] st;
        logic       go;
        logic       wl;
        logic       wr;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       mo;
    } exp_t;

    typedef struct packed {
        logic rstn;
        logic s;
        logic l;
        logic r;
        exp_t e;
    } vec_t;

    exp_t obs;
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

`ifdef TOW_FALSE_START_EN
    localparam bit FS = 1'b1;
`else
    localparam bit FS = 1'b0;
`endif

    localparam logic [4:0] C = 5'b00100;

    tow_referee #(.LEDS(5), .COUNT_CYC(4), .MATCH(2)) dut (
        .clk(clk), .rst(rst), .start(start), .pl(pl), .pr(pr),
        .pos(pos), .state(state), .go(go), .win_l(win_l), .win_r(win_r),
        .score_l(score_l), .score_r(score_r), .match_over(match_over)
    );

    always #5 clk = ~clk;

    assign obs = {pos, state, go, win_l, win_r, score_l, score_r, match_over};

    function automatic exp_t mk(input logic [4:0] p, input logic [1:0] st, input logic g,
                                input logic wl, input logic wr, input logic [3:0] sl,
                                input logic [3:0] sr, input logic mo);
        return '{pos: p, st: st, go: g, wl: wl, wr: wr, sl: sl, sr: sr, mo: mo};
    endfunction

    function automatic vec_t v(input logic rn, input logic s, input logic l, input logic r,
                               input exp_t e);
        return '{rstn: rn, s: s, l: l, r: r, e: e};
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after its edge.
    task automatic apply(input vec_t t);
        sb.push_back(t.e);
        rst = t.rstn; start = t.s; pl = t.l; pr = t.r;
        @(posedge clk);
        #1;
        start = 1'b0; pl = 1'b0; pr = 1'b0; rst = 1'b1;
    endtask

    task automatic test_reset();
        vec_t t[$];
        exp_t e;
        t = '{v(0,1,1,0, mk(C,0,0,0,0,0,0,0)),
              v(0,0,0,0, mk(C,0,0,0,0,0,0,0))};
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL reset[%0d] got %b want %b", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_count_play();
        vec_t t[$];
        exp_t e;
        t = '{v(1,0,1,0, mk(C,0,0,0,0,0,0,0)),
              v(1,0,0,1, mk(C,0,0,0,0,0,0,0)),
              v(1,1,0,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,0,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,0,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,0,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,0,0, mk(C,2,1,0,0,0,0,0))};
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL count_play[%0d] got %b want %b", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_left_win();
        vec_t t[$];
        exp_t e;
        t = '{v(1,0,1,0, mk(5'b01000,2,1,0,0,0,0,0)),
              v(1,0,1,0, mk(5'b10000,3,0,1,0,1,0,0)),
              v(1,0,1,0, mk(5'b10000,3,0,1,0,1,0,0)),
              v(1,0,0,1, mk(5'b10000,3,0,1,0,1,0,0)),
              v(1,1,0,0, mk(C,1,0,0,0,1,0,0)),
              v(1,0,0,0, mk(C,1,0,0,0,1,0,0)),
              v(1,1,0,0, mk(C,1,0,0,0,1,0,0)),
              v(1,0,0,0, mk(C,1,0,0,0,1,0,0)),
              v(1,0,0,0, mk(C,2,1,0,0,1,0,0))};
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL left_win[%0d] got %b want %b", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_contest();
        vec_t t[$];
        exp_t e;
        t = '{v(1,0,1,1, mk(C,2,1,0,0,1,0,0)),
              v(1,0,0,1, mk(5'b00010,2,1,0,0,1,0,0)),
              v(1,1,0,0, mk(5'b00010,2,1,0,0,1,0,0)),
              v(1,0,1,0, mk(C,2,1,0,0,1,0,0)),
              v(1,0,0,1, mk(5'b00010,2,1,0,0,1,0,0)),
              v(1,0,0,1, mk(5'b00001,3,0,0,1,1,1,0))};
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL contest[%0d] got %b want %b", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_match();
        vec_t t[$];
        exp_t e;
        t = '{v(1,1,0,0, mk(C,1,0,0,0,1,1,0)),
              v(1,0,0,!FS, mk(C,1,0,0,0,1,1,0)),
              v(1,0,0,0, mk(C,1,0,0,0,1,1,0)),
              v(1,0,0,0, mk(C,1,0,0,0,1,1,0)),
              v(1,0,0,0, mk(C,2,1,0,0,1,1,0)),
              v(1,0,1,0, mk(5'b01000,2,1,0,0,1,1,0)),
              v(1,0,1,0, mk(5'b10000,3,0,1,0,2,1,1)),
              v(1,1,0,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,0,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,0,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,0,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,0,0, mk(C,2,1,0,0,0,0,0)),
              v(1,0,0,1, mk(5'b00010,2,1,0,0,0,0,0)),
              v(0,1,1,0, mk(C,0,0,0,0,0,0,0))};
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL match[%0d] got %b want %b", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_false_start();
        vec_t t[$];
        exp_t e;
`ifdef TOW_FALSE_START_EN
        t = '{v(1,1,0,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,0,1, mk(5'b10000,3,0,1,0,1,0,0)),
              v(1,1,0,0, mk(C,1,0,0,0,1,0,0)),
              v(1,0,1,0, mk(5'b00001,3,0,0,1,1,1,0)),
              v(1,1,0,0, mk(C,1,0,0,0,1,1,0)),
              v(1,0,1,1, mk(C,1,0,0,0,1,1,0)),
              v(1,0,0,0, mk(C,1,0,0,0,1,1,0)),
              v(1,0,0,0, mk(C,1,0,0,0,1,1,0)),
              v(1,0,0,0, mk(C,1,0,0,0,1,1,0)),
              v(1,0,0,0, mk(C,2,1,0,0,1,1,0))};
`else
        t = '{v(1,1,0,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,1,1, mk(C,1,0,0,0,0,0,0)),
              v(1,0,1,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,0,0, mk(C,1,0,0,0,0,0,0)),
              v(1,0,0,0, mk(C,2,1,0,0,0,0,0))};
`endif
        foreach (t[i]) begin
            apply(t[i]);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL false_start[%0d] got %b want %b", i, obs, e);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; pl = 1'b0; pr = 1'b0;
        test_reset();
        test_count_play();
        test_left_win();
        test_contest();
        test_match();
        test_false_start();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
